// File: rtl/uart_rx_pkt_ctrl_if.sv
// Signal bundle between the UART byte receiver / payload consumer side and
// the packet controller.
//
// Handshake semantics on the out_* stream: a byte transfers on every clk edge
// where out_valid_o and out_ready_i are both high; while out_valid_o is high
// and out_ready_i is low, out_data_o and out_last_o hold steady. The rx_*
// inputs are one-cycle strobes with no back-pressure.
interface uart_rx_pkt_ctrl_if #(
    parameter int LEN_W = 5
);
    logic             rx_valid_i;
    logic [7:0]       rx_data_i;
    logic             rx_err_i;
    logic             out_valid_o;
    logic [7:0]       out_data_o;
    logic             out_last_o;
    logic             out_ready_i;
    logic             pkt_ok_o;
    logic [LEN_W-1:0] pkt_len_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic             drop_o;

    // Receiver/consumer side: drives bytes and ready, observes results.
    modport master (
        output rx_valid_i, rx_data_i, rx_err_i, out_ready_i,
        input  out_valid_o, out_data_o, out_last_o,
        input  pkt_ok_o, pkt_len_o, err_o, err_code_o, drop_o
    );

    // Packet controller side.
    modport slave (
        input  rx_valid_i, rx_data_i, rx_err_i, out_ready_i,
        output out_valid_o, out_data_o, out_last_o,
        output pkt_ok_o, pkt_len_o, err_o, err_code_o, drop_o
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind a UART byte receiver: sync hunt, length, payload
// buffering, XOR checksum, inter-byte timeout, then drains the payload over a
// valid/ready stream. Aborts pulse err_o with a code and return to sync hunt.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_pkt_ctrl_if.slave     bus,
    output logic [2:0]            state_dbg
);
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_PAYLOAD);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  ONE_T     = TO_W'(1);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic [7:0]       csum, csum_n;
    logic [LEN_W-1:0] wr_ptr, wr_ptr_n;
    logic [LEN_W-1:0] rd_ptr, rd_ptr_n;
    logic [TO_W-1:0]  to_cnt, to_n;
    logic             pkt_ok, pkt_ok_n;
    logic [LEN_W-1:0] pkt_len, pkt_len_n;
    logic             err, err_n;
    logic [1:0]       err_code, err_code_n;
    logic             drop, drop_n;
    logic             wr_en;
    logic [7:0]       buf_mem [MAX_PAYLOAD];

    // A byte only counts when no framing error arrives in the same cycle.
    logic byte_in;
    logic in_pkt;
    assign byte_in = bus.rx_valid_i && !bus.rx_err_i;
    assign in_pkt  = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

    // State, pointers, checksum and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            len      <= '0;
            csum     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            to_cnt   <= '0;
            pkt_ok   <= 1'b0;
            pkt_len  <= '0;
            err      <= 1'b0;
            err_code <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            csum     <= csum_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            to_cnt   <= to_n;
            pkt_ok   <= pkt_ok_n;
            pkt_len  <= pkt_len_n;
            err      <= err_n;
            err_code <= err_code_n;
            drop     <= drop_n;
        end
    end

    // Payload buffer; survives aborts, only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) buf_mem[i] <= '0;
        end else if (wr_en) begin
            buf_mem[wr_ptr[IDX_W-1:0]] <= bus.rx_data_i;
        end
    end

    // Next-state, datapath updates and pulse generation.
    always_comb begin
        state_n    = state;
        len_n      = len;
        csum_n     = csum;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        to_n       = '0;
        pkt_ok_n   = 1'b0;
        pkt_len_n  = pkt_len;
        err_n      = 1'b0;
        err_code_n = err_code;
        drop_n     = 1'b0;
        wr_en      = 1'b0;

        if (in_pkt) to_n = bus.rx_valid_i ? '0 : to_cnt + ONE_T;

        case (state)
            HUNT: begin
                if (byte_in && bus.rx_data_i == SYNC_BYTE) state_n = LEN;
            end
            LEN, PAYLOAD, CSUM: begin
                if (bus.rx_err_i) begin
                    err_n = 1'b1; err_code_n = 2'd3; state_n = HUNT;
                end else if (byte_in) begin
                    if (state == LEN) begin
                        if (bus.rx_data_i > MAX_LEN_B) begin
                            err_n = 1'b1; err_code_n = 2'd1; state_n = HUNT;
                        end else begin
                            len_n    = bus.rx_data_i[LEN_W-1:0];
                            csum_n   = bus.rx_data_i;
                            wr_ptr_n = '0;
                            state_n  = (bus.rx_data_i == 8'd0) ? CSUM : PAYLOAD;
                        end
                    end else if (state == PAYLOAD) begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_ptr + ONE_L;
                        csum_n   = csum ^ bus.rx_data_i;
                        if (wr_ptr + ONE_L == len) state_n = CSUM;
                    end else begin
                        if (bus.rx_data_i == csum) begin
                            pkt_ok_n  = 1'b1;
                            pkt_len_n = len;
                            state_n   = (len == '0) ? HUNT : DRAIN;
                        end else begin
                            err_n = 1'b1; err_code_n = 2'd0; state_n = HUNT;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_n = 1'b1; err_code_n = 2'd2; state_n = HUNT;
                end
            end
            DRAIN: begin
                if (bus.rx_valid_i) drop_n = 1'b1;
                if (bus.out_ready_i) begin
                    if (rd_ptr == len - ONE_L) state_n = HUNT;
                    else rd_ptr_n = rd_ptr + ONE_L;
                end
            end
            default: state_n = HUNT;
        endcase

        // Every return to sync hunt starts the next packet from clean pointers.
        if (state_n == HUNT) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end
    end

    assign bus.out_valid_o = (state == DRAIN);
    assign bus.out_data_o  = buf_mem[rd_ptr[IDX_W-1:0]];
    assign bus.out_last_o  = (state == DRAIN) && (rd_ptr == len - ONE_L);
    assign bus.pkt_ok_o    = pkt_ok;
    assign bus.pkt_len_o   = pkt_len;
    assign bus.err_o       = err;
    assign bus.err_code_o  = err_code;
    assign bus.drop_o      = drop;
    assign state_dbg       = state;
endmodule
